// File: rtl/rtc_pdu_apbif.sv
// rtc_pdu_apbif: APB3 slave front-end of the RTC (power-down domain).
// Decodes APB transfers into one-cycle write strobes for the always-on
// register bank, reads back the AOU register copies, fetches the RTC counter
// through a toggle req/ack handshake and owns the raw/masked interrupt status.
// Optional feature macro: RTC_PDU_PSLVERR_EN enables the pslverr response for
// writes to read-only/unmapped offsets, reads of unmapped offsets and
// counter-capture timeouts; without it pslverr is tied low.
`timescale 1ns/1ps

module rtc_pdu_apbif #(
  parameter int          ADDR_W       = 8,
  parameter int          CNT_TIMEOUT  = 64,
  parameter logic [31:0] COMP_VERSION = 32'h3230312A
) (
  input  logic              pclk_gate,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              pdu_aou_wen_mr,
  output logic              pdu_aou_wen_cr,
  output logic              pdu_aou_wen_div,
  output logic [31:0]       pdu_aou_pwdata,
  input  logic [31:0]       aou_pdu_mr_reg,
  input  logic [3:0]        aou_pdu_cr_reg,
  input  logic [19:0]       aou_pdu_div_reg,
  output logic              rtc_cnt_req,
  input  logic              rtc_cnt_ack,
  input  logic [31:0]       rtc_cnt_val,
  input  logic              rtc_match_tgl,
  output logic              rtc_intr
);

  localparam int OFF_W = ADDR_W - 2;
  localparam int TO_W  = $clog2(CNT_TIMEOUT + 1);

  localparam logic [OFF_W-1:0] OFF_CCVR  = OFF_W'(0);
  localparam logic [OFF_W-1:0] OFF_CMR   = OFF_W'(1);
  localparam logic [OFF_W-1:0] OFF_CCR   = OFF_W'(3);
  localparam logic [OFF_W-1:0] OFF_STAT  = OFF_W'(4);
  localparam logic [OFF_W-1:0] OFF_RSTAT = OFF_W'(5);
  localparam logic [OFF_W-1:0] OFF_EOI   = OFF_W'(6);
  localparam logic [OFF_W-1:0] OFF_VER   = OFF_W'(7);
  localparam logic [OFF_W-1:0] OFF_DIV   = OFF_W'(8);

`ifdef RTC_PDU_PSLVERR_EN
  localparam logic PSLVERR_EN = 1'b1;
`else
  localparam logic PSLVERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_CNTWAIT,
    ST_CNTDONE
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              req_sent_q, req_sent_d;   // our own toggle is in flight
  logic              timeout_q, timeout_d;
  logic [TO_W-1:0]   wait_q, wait_d;
  logic [31:0]       prdata_q;
  logic              cap_en;
  logic [1:0]        ack_sync;
  logic [2:0]        match_sync;
  logic              raw_q, intr_q;
  logic              err_c;

  logic [OFF_W-1:0]  off;
  logic              access, wr_xfer, rd_xfer;
  logic              ack_s, match_evt, eoi_clr, stat;
  logic [31:0]       rd_data;
  logic              rd_mapped, wr_ok;
  logic              unused_paddr_lsb;

  assign off              = paddr[ADDR_W-1:2];
  assign unused_paddr_lsb = ^paddr[1:0];
  assign access           = (state_q == ST_ACCESS) & psel & penable;
  assign wr_xfer          = access & pwrite;
  assign rd_xfer          = access & ~pwrite;
  assign ack_s            = ack_sync[1];
  assign match_evt        = match_sync[2] ^ match_sync[1];
  assign stat             = raw_q & aou_pdu_cr_reg[0] & ~aou_pdu_cr_reg[1];
  assign wr_ok            = (off == OFF_CMR) | (off == OFF_CCR) | (off == OFF_DIV);

  // Write strobes: one cycle, only in the access phase of a writable offset.
  assign pdu_aou_wen_mr  = wr_xfer & (off == OFF_CMR);
  assign pdu_aou_wen_cr  = wr_xfer & (off == OFF_CCR);
  assign pdu_aou_wen_div = wr_xfer & (off == OFF_DIV);
  assign pdu_aou_pwdata  = pwdata;

  // A completed EOI read clears the raw status.
  assign eoi_clr = rd_xfer & (off == OFF_EOI);

  assign rtc_cnt_req = req_q;
  assign rtc_intr    = intr_q;

  // Read-data mux for zero-wait reads; also flags unmapped offsets.
  always_comb begin
    rd_data   = '0;
    rd_mapped = 1'b1;
    case (off)
      OFF_CCVR:          rd_data = prdata_q;
      OFF_CMR:           rd_data = aou_pdu_mr_reg;
      OFF_CCR:           rd_data = {28'b0, aou_pdu_cr_reg};
      OFF_STAT:          rd_data = {31'b0, stat};
      OFF_RSTAT, OFF_EOI: rd_data = {31'b0, raw_q};
      OFF_VER:           rd_data = COMP_VERSION;
      OFF_DIV:           rd_data = {12'b0, aou_pdu_div_reg};
      default:           rd_mapped = 1'b0;
    endcase
  end

  // Transfer FSM next-state, handshake control and APB response.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can leave it unassigned and infer a latch.
    state_d    = state_q;
    req_d      = req_q;
    req_sent_d = req_sent_q;
    timeout_d  = timeout_q;
    wait_d     = wait_q;
    cap_en     = 1'b0;
    pready     = 1'b0;
    prdata     = '0;
    err_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (psel) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else if (penable) begin
          if (!pwrite && (off == OFF_CCVR)) begin
            state_d   = ST_CNTWAIT;
            wait_d    = '0;
            timeout_d = 1'b0;
            // Only toggle once any ack from an abandoned request has landed.
            if (req_q == ack_s) begin
              req_d      = ~req_q;
              req_sent_d = 1'b1;
            end else begin
              req_sent_d = 1'b0;
            end
          end else begin
            pready  = 1'b1;
            prdata  = pwrite ? 32'h0 : rd_data;
            err_c   = pwrite ? ~wr_ok : ~rd_mapped;
            state_d = ST_IDLE;
          end
        end
      end
      ST_CNTWAIT: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else if (req_sent_q && (ack_s == req_q)) begin
          cap_en  = 1'b1;
          state_d = ST_CNTDONE;
        end else if (wait_q == TO_W'(CNT_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_CNTDONE;
        end else begin
          wait_d = wait_q + 1'b1;
          if (!req_sent_q && (ack_s == req_q)) begin
            req_d      = ~req_q;
            req_sent_d = 1'b1;
          end
        end
      end
      ST_CNTDONE: begin
        pready  = 1'b1;
        prdata  = prdata_q;
        err_c   = timeout_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    pslverr = PSLVERR_EN & err_c;
  end

  // FSM state, handshake bookkeeping and counter snapshot register.
  always_ff @(posedge pclk_gate or negedge presetn) begin
    if (!presetn) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      req_sent_q <= 1'b0;
      timeout_q  <= 1'b0;
      wait_q     <= '0;
      prdata_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      req_q      <= req_d;
      req_sent_q <= req_sent_d;
      timeout_q  <= timeout_d;
      wait_q     <= wait_d;
      if (cap_en) prdata_q <= rtc_cnt_val;
    end
  end

  // Two-flop synchronizers for the RTC-domain toggles, plus match edge history.
  always_ff @(posedge pclk_gate or negedge presetn) begin
    if (!presetn) begin
      ack_sync   <= '0;
      match_sync <= '0;
    end else begin
      ack_sync   <= {ack_sync[0], rtc_cnt_ack};
      match_sync <= {match_sync[1:0], rtc_match_tgl};
    end
  end

  // Raw status (set wins over EOI clear) and registered masked interrupt.
  always_ff @(posedge pclk_gate or negedge presetn) begin
    if (!presetn) begin
      raw_q  <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      raw_q  <= match_evt | (raw_q & ~eoi_clr);
      intr_q <= stat;
    end
  end

endmodule

// File: tb/tb_rtc_pdu_apbif.sv
// tb_rtc_pdu_apbif: directed bench for rtc_pdu_apbif with a read scoreboard,
// a behavioural RTC-side ack responder and strobe monitors.
`timescale 1ns/1ps

module tb_rtc_pdu_apbif;

  localparam int          ADDR_W  = 8;
  localparam int          TO      = 16;
  localparam int          ACK_DLY = 5;
  localparam logic [31:0] VER     = 32'h3230312A;
`ifdef RTC_PDU_PSLVERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic              pclk_gate = 1'b0;
  logic              presetn;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready, pslverr;
  logic              wen_mr, wen_cr, wen_div;
  logic [31:0]       aou_pwdata;
  logic [31:0]       mr_reg;
  logic [3:0]        cr_reg;
  logic [19:0]       div_reg;
  logic              rtc_cnt_req;
  logic              ack_r = 1'b0;
  logic [31:0]       cnt_val;
  logic              match_tgl;
  logic              rtc_intr;

  rtc_pdu_apbif #(
    .ADDR_W      (ADDR_W),
    .CNT_TIMEOUT (TO),
    .COMP_VERSION(VER)
  ) dut (
    .pclk_gate      (pclk_gate),
    .presetn        (presetn),
    .psel           (psel),
    .penable        (penable),
    .pwrite         (pwrite),
    .paddr          (paddr),
    .pwdata         (pwdata),
    .prdata         (prdata),
    .pready         (pready),
    .pslverr        (pslverr),
    .pdu_aou_wen_mr (wen_mr),
    .pdu_aou_wen_cr (wen_cr),
    .pdu_aou_wen_div(wen_div),
    .pdu_aou_pwdata (aou_pwdata),
    .aou_pdu_mr_reg (mr_reg),
    .aou_pdu_cr_reg (cr_reg),
    .aou_pdu_div_reg(div_reg),
    .rtc_cnt_req    (rtc_cnt_req),
    .rtc_cnt_ack    (ack_r),
    .rtc_cnt_val    (cnt_val),
    .rtc_match_tgl  (match_tgl),
    .rtc_intr       (rtc_intr)
  );

  always #5 pclk_gate = ~pclk_gate;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  // RTC-side responder: echoes a req toggle on ack after ACK_DLY cycles.
  bit ack_auto;
  int ack_cnt = 0;
  always @(posedge pclk_gate) begin
    if (ack_auto && (rtc_cnt_req !== ack_r)) begin
      if (ack_cnt >= ACK_DLY - 1) begin
        ack_r   <= rtc_cnt_req;
        ack_cnt <= 0;
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end else begin
      ack_cnt <= 0;
    end
  end

  // Strobe monitors: count strobe cycles and capture qualified write data.
  int          n_mr = 0, n_cr = 0, n_div = 0;
  logic [31:0] last_wdata = '0;
  always @(negedge pclk_gate) begin
    if (wen_mr)  begin n_mr++;  last_wdata = aou_pwdata; end
    if (wen_cr)  begin n_cr++;  last_wdata = aou_pwdata; end
    if (wen_div) begin n_div++; last_wdata = aou_pwdata; end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int last_waits;

  // One APB transfer; waits counts access-phase cycles sampled with pready low.
  task automatic apb_xfer(input logic wr, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int waits);
    @(posedge pclk_gate); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge pclk_gate); #1;
    penable = 1'b1;
    waits = 0;
    @(negedge pclk_gate);
    while (!pready && waits < 200) begin
      waits++;
      @(negedge pclk_gate);
    end
    check("xfer_done", {31'b0, pready}, 32'd1);
    rdata = prdata;
    err   = pslverr;
    @(posedge pclk_gate); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input string tag, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] exp_data, input logic exp_err);
    exp_t e;
    logic [31:0] rd;
    logic er;
    int w;
    e.data = exp_data;
    e.err  = exp_err;
    sb_q.push_back(e);
    apb_xfer(1'b0, addr, 32'h0, rd, er, w);
    last_waits = w;
    e = sb_q.pop_front();
    check({tag, "_data"}, rd, e.data);
    check({tag, "_err"}, {31'b0, er}, {31'b0, e.err});
  endtask

  task automatic apb_write(input string tag, input logic [ADDR_W-1:0] addr,
                           input logic [31:0] data, input logic exp_err);
    exp_t e;
    logic [31:0] rd;
    logic er;
    int w;
    e.data = 32'h0;
    e.err  = exp_err;
    sb_q.push_back(e);
    apb_xfer(1'b1, addr, data, rd, er, w);
    e = sb_q.pop_front();
    check({tag, "_err"}, {31'b0, er}, {31'b0, e.err});
  endtask

  initial begin
    int n0, c0, d0, w;
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    mr_reg = 32'hA5A5_0001; cr_reg = 4'b1010; div_reg = 20'h7_FFFF;
    cnt_val = '0; match_tgl = 1'b0; ack_auto = 1'b1;

    // Reset state.
    repeat (3) @(posedge pclk_gate);
    @(negedge pclk_gate);
    check("rst_prdata", prdata, 32'h0);
    check("rst_pready", {31'b0, pready}, 32'h0);
    check("rst_intr", {31'b0, rtc_intr}, 32'h0);
    check("rst_req", {31'b0, rtc_cnt_req}, 32'h0);
    check("rst_strobes", {29'b0, wen_mr, wen_cr, wen_div}, 32'h0);
    @(posedge pclk_gate); #1 presetn = 1'b1;
    @(negedge pclk_gate);
    check("post_rst_pready", {31'b0, pready}, 32'h0);

    // Writes to writable offsets: exactly one strobe each.
    n0 = n_mr; c0 = n_cr; d0 = n_div;
    apb_write("wr_mr", 8'h04, 32'h0000_1234, 1'b0);
    check("wen_mr_once", 32'(n_mr - n0), 32'd1);
    check("wen_mr_data", last_wdata, 32'h0000_1234);
    check("wen_mr_only", 32'((n_cr - c0) + (n_div - d0)), 32'd0);
    apb_read("rd_mr", 8'h04, 32'hA5A5_0001, 1'b0);
    c0 = n_cr;
    apb_write("wr_cr", 8'h0C, 32'h0000_0005, 1'b0);
    check("wen_cr_once", 32'(n_cr - c0), 32'd1);
    check("wen_cr_data", last_wdata, 32'h0000_0005);
    d0 = n_div;
    apb_write("wr_div", 8'h20, 32'h0001_2345, 1'b0);
    check("wen_div_once", 32'(n_div - d0), 32'd1);

    // Writes to read-only / unmapped offsets: no strobe.
    n0 = n_mr + n_cr + n_div;
    apb_write("wr_stat_ro", 8'h10, 32'hFFFF_FFFF, EXP_ERR);
    apb_write("wr_ccvr_ro", 8'h00, 32'hFFFF_FFFF, EXP_ERR);
    apb_write("wr_unmapped", 8'h24, 32'hFFFF_FFFF, EXP_ERR);
    check("ro_no_strobe", 32'(n_mr + n_cr + n_div - n0), 32'd0);

    // Register reads.
    apb_read("rd_cr", 8'h0C, 32'h0000_000A, 1'b0);
    apb_read("rd_div", 8'h20, 32'h0007_FFFF, 1'b0);
    apb_read("rd_ver", 8'h1C, VER, 1'b0);
    apb_read("rd_unmapped", 8'h08, 32'h0, EXP_ERR);
    apb_read("rd_stat0", 8'h10, 32'h0, 1'b0);
    apb_read("rd_rstat0", 8'h14, 32'h0, 1'b0);

    // psel dropped in the access phase: no strobe, bus recovers.
    n0 = n_mr;
    @(posedge pclk_gate); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'h5555_5555;
    @(posedge pclk_gate); #1;
    psel = 1'b0; penable = 1'b1;
    @(negedge pclk_gate);
    check("drop_pready", {31'b0, pready}, 32'h0);
    @(posedge pclk_gate); #1;
    penable = 1'b0; pwrite = 1'b0;
    repeat (2) @(negedge pclk_gate);
    check("drop_no_strobe", 32'(n_mr - n0), 32'd0);
    apb_read("rd_after_drop", 8'h04, 32'hA5A5_0001, 1'b0);

    // Counter fetch through the handshake.
    cnt_val = 32'hDEAD_BEEF;
    apb_read("ccvr", 8'h00, 32'hDEAD_BEEF, 1'b0);
    w = last_waits;
    check($sformatf("ccvr_latency(waits=%0d)", w), 32'(w >= 7 && w <= 11), 32'd1);

    // No ack: timeout returns the last captured value.
    ack_auto = 1'b0;
    cnt_val  = 32'h1111_2222;
    apb_read("ccvr_to", 8'h00, 32'hDEAD_BEEF, EXP_ERR);
    w = last_waits;
    check($sformatf("ccvr_to_latency(waits=%0d)", w), 32'(w >= TO && w <= TO + 2), 32'd1);

    // Stale ack still in flight: the read must drain it before a new toggle.
    cnt_val  = 32'h0BAD_F00D;
    ack_auto = 1'b1;
    apb_read("ccvr_drain", 8'h00, 32'h0BAD_F00D, 1'b0);
    w = last_waits;
    check($sformatf("ccvr_drain_latency(waits=%0d)", w), 32'(w >= 12 && w <= 30), 32'd1);
    cnt_val = 32'h1357_9BDF;
    apb_read("ccvr2", 8'h00, 32'h1357_9BDF, 1'b0);

    // Reset in the middle of a counter wait.
    ack_auto = 1'b0;
    @(posedge pclk_gate); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00;
    @(posedge pclk_gate); #1;
    penable = 1'b1;
    repeat (4) @(posedge pclk_gate);
    #1 presetn = 1'b0;
    @(negedge pclk_gate);
    check("midrst_req", {31'b0, rtc_cnt_req}, 32'h0);
    check("midrst_pready", {31'b0, pready}, 32'h0);
    check("midrst_prdata", prdata, 32'h0);
    @(posedge pclk_gate); #1;
    psel = 1'b0; penable = 1'b0; presetn = 1'b1;
    ack_auto = 1'b1;
    cnt_val  = 32'h2468_ACE0;
    apb_read("ccvr_after_rst", 8'h00, 32'h2468_ACE0, 1'b0);
    w = last_waits;
    check($sformatf("ccvr_after_rst_latency(waits=%0d)", w), 32'(w >= 7 && w <= 11), 32'd1);

    // Interrupt enabled and unmasked.
    cr_reg = 4'b0001;
    @(posedge pclk_gate); #1 match_tgl = ~match_tgl;
    w = 0;
    @(negedge pclk_gate);
    while (!rtc_intr && w < 10) begin
      w++;
      @(negedge pclk_gate);
    end
    check("intr_set", {31'b0, rtc_intr}, 32'd1);
    check($sformatf("intr_latency(cycles=%0d)", w), 32'(w <= 4), 32'd1);
    apb_read("rstat_set", 8'h14, 32'h1, 1'b0);
    apb_read("stat_set", 8'h10, 32'h1, 1'b0);
    apb_read("eoi_read", 8'h18, 32'h1, 1'b0);
    repeat (2) @(negedge pclk_gate);
    check("intr_cleared", {31'b0, rtc_intr}, 32'h0);
    apb_read("rstat_cleared", 8'h14, 32'h0, 1'b0);

    // Interrupt masked: raw sets, STAT and rtc_intr stay low.
    cr_reg = 4'b0011;
    @(posedge pclk_gate); #1 match_tgl = ~match_tgl;
    repeat (6) @(negedge pclk_gate);
    check("masked_intr", {31'b0, rtc_intr}, 32'h0);
    apb_read("masked_rstat", 8'h14, 32'h1, 1'b0);
    apb_read("masked_stat", 8'h10, 32'h0, 1'b0);
    apb_read("masked_eoi", 8'h18, 32'h1, 1'b0);
    apb_read("masked_rstat_clr", 8'h14, 32'h0, 1'b0);

    // Match event lands in the same cycle an EOI read completes: set wins.
    cr_reg = 4'b0001;
    begin
      exp_t e;
      e.data = 32'h0;
      e.err  = 1'b0;
      @(posedge pclk_gate); #1 match_tgl = ~match_tgl;
      @(posedge pclk_gate); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h18;
      sb_q.push_back(e);
      @(posedge pclk_gate); #1;
      penable = 1'b1;
      @(negedge pclk_gate);
      check("race_eoi_pready", {31'b0, pready}, 32'd1);
      e = sb_q.pop_front();
      check("race_eoi_data", prdata, e.data);
      @(posedge pclk_gate); #1;
      psel = 1'b0; penable = 1'b0;
    end
    apb_read("race_rstat", 8'h14, 32'h1, 1'b0);
    check("race_intr", {31'b0, rtc_intr}, 32'd1);
    apb_read("race_eoi_clear", 8'h18, 32'h1, 1'b0);
    apb_read("race_rstat_clr", 8'h14, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
